irq_controller: RTL and testbench
=================================

# irq_controller

Interrupt controller that sequences the control unit of the fetch/execute core. It latches rising edges on external interrupt lines into pending bits and applies a per-line mask and a global interrupt flag (I). It picks the highest-priority pending line and asks the control unit to divert the PC to that line's vector, using a req/ack handshake taken at an instruction boundary. It sits beside the control unit; its vector output feeds the PC-load path in place of the branch constant.

## Interface
Parameters:
- N_IRQ, 4, number of interrupt lines (1..8)
- VECTOR_BASE, 16'h0002, vector address of line 0
- VECTOR_STRIDE, 2, vector spacing in words

Ports (one clock, i_clk; reset i_reset is synchronous, active-high):
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_irq  in  N_IRQ  interrupt lines, rising-edge sensitive, synchronous to i_clk
- i_mask  in  N_IRQ  per-line enable, 1 = enabled
- i_sei  in  1  control unit executing SEI (1-cycle pulse)
- i_cli  in  1  control unit executing CLI (1-cycle pulse)
- i_reti  in  1  control unit executing RETI (1-cycle pulse)
- i_ack  in  1  control unit accepts the request at an instruction boundary (1-cycle pulse)
- o_req  out  1  interrupt request to the control unit
- o_vector  out  16  vector address, valid and stable while o_req = 1
- o_irq_id  out  3  index of the requested line
- o_gie  out  1  global interrupt flag I
- o_pending  out  N_IRQ  pending bits

## Operation
- Edge detect: prev <= i_irq every cycle. A rising edge is i_irq & ~prev. Each rising edge sets the matching pending bit.
- Priority: the lowest index among (pending & i_mask) wins.
- Vector: VECTOR_BASE + id*VECTOR_STRIDE, truncated to 16 bits (wraps mod 2^16).
- GIE updates:
  - i_sei or i_reti sets GIE.
  - i_cli or an accepted i_ack clears GIE.
  - Clear has priority over set in the same cycle.
- FSM states IDLE, REQUEST, SERVICE:
  - IDLE: if GIE=1 and (pending & i_mask) != 0, latch the winning id and vector, then go to REQUEST.
  - REQUEST: o_req=1; id and vector are frozen.
    - i_ack: clear pending[id], clear GIE, go to SERVICE.
    - No i_ack and (i_cli, or i_mask[id]=0): withdraw to IDLE. Pending is kept.
    - i_ack wins over i_cli in the same cycle.
  - SERVICE: o_req=0. On i_reti or i_sei, GIE=1 and go to IDLE (nesting allowed after SEI).
- i_ack outside REQUEST is ignored.
- A new edge on line id in the ack cycle leaves pending[id]=1 (set wins over clear).
- Reset values:
  - state IDLE, GIE=0, pending=0, o_req=0, o_vector=VECTOR_BASE, o_irq_id=0.
  - prev <= i_irq, so a line held high through reset produces no edge.
- Reset mid-REQUEST or mid-SERVICE discards everything; the request is lost.

## Timing
- All outputs are registered.
- An edge sampled at clock n sets pending at n+1. o_req rises at n+2 if GIE=1 and the state is IDLE.
- A GIE set at n, with the line already pending and the state IDLE, gives o_req at n+2.
- After i_ack at n: o_req=0, o_gie=0 and the pending bit cleared, all at n+1.
- After i_cli or a mask drop in REQUEST at n: o_req=0 at n+1.
- After i_reti at n: o_gie=1 at n+1, and o_req for another pending line at n+2.
- o_vector and o_irq_id do not change while o_req=1.

## Structure
- Shared package irq_pkg holds:
  - state encoding (IDLE, REQUEST, SERVICE)
  - default VECTOR_BASE and VECTOR_STRIDE
  - MAX_IRQ = 8
- Sub-module irq_pending: edge detection plus pending set/clear. Inputs are i_irq, a clear-enable and a clear-index; output is pending.
- The top level holds GIE, the priority encoder, vector arithmetic and the FSM.

## Test plan
All scenarios use N_IRQ=4, VECTOR_BASE=0x0002, VECTOR_STRIDE=2.
- Basic request: reset, i_mask=4'hF, pulse i_sei, rise i_irq[2] at n -> o_req=1 at n+2 with o_vector=0x0006 and o_irq_id=2. Then i_ack -> next cycle o_req=0, o_gie=0, o_pending[2]=0.
- Priority: i_irq[1] and i_irq[3] rise together -> id 1, vector 0x0004. After ack and i_reti -> id 3, vector 0x0008, o_req two cycles after reti.
- Gated by GIE: with GIE=0, an edge on i_irq[0] -> o_pending[0]=1 and o_req stays 0. i_sei at n -> o_req at n+2 with vector 0x0002.
- Withdraw: in REQUEST for id 2, pulse i_cli -> o_req=0 next cycle and o_pending[2] still 1. i_sei -> the same id is re-requested.
  - Repeat with i_mask[2] cleared instead of i_cli: same withdraw. Repeat with i_ack and i_cli in the same cycle: the ack is taken.
- Collision: a new edge on i_irq[2] in the i_ack cycle -> o_pending[2]=1 afterwards. i_reti -> id 2 is requested again.
- Reset: assert i_reset during REQUEST with i_irq[1] held high -> next cycle all outputs at reset values. After release and i_sei, no request appears until a fresh rising edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, vector defaults
// and the vector address helper.
package irq_pkg;

  localparam int          MAX_IRQ           = 8;
  localparam logic [15:0] DEF_VECTOR_BASE   = 16'h0002;
  localparam int          DEF_VECTOR_STRIDE = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Vector of line id; the sum deliberately wraps modulo 2^16.
  function automatic logic [15:0] vector_addr(input logic [15:0] base, input int stride,
                                              input logic [2:0] id);
    logic [31:0] full;
    full = {16'h0000, base} + (32'(id) * 32'(stride));
    return full[15:0];
  endfunction

endpackage

// File: rtl/irq_pending.sv
// Rising-edge detection on the interrupt lines and the pending register.
// A new edge in the same cycle as a clear leaves the bit set.
module irq_pending
  import irq_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_clr_en,
  input  logic [2:0]       i_clr_idx,
  output logic [N_IRQ-1:0] o_pending
);

  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] pending_d;
  logic [N_IRQ-1:0] clr_s;

  // Next pending value: clear the acknowledged line, then OR in fresh edges.
  always_comb begin
    clr_s = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr_s[i] = i_clr_en && (i_clr_idx == 3'(i));
    end
    pending_d = (pending_q & ~clr_s) | (i_irq & ~prev_q);
  end

  // prev tracks the lines even in reset so a level held through reset is not an edge.
  always_ff @(posedge i_clk) begin
    prev_q <= i_irq;
    if (i_reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign o_pending = pending_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: global enable flag, fixed lowest-index priority, vector
// generation and the req/ack handshake with the control unit.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          N_IRQ         = 4,
  parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter int          VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic [N_IRQ-1:0] i_mask,
  input  logic             i_sei,
  input  logic             i_cli,
  input  logic             i_reti,
  input  logic             i_ack,
  output logic             o_req,
  output logic [15:0]      o_vector,
  output logic [2:0]       o_irq_id,
  output logic             o_gie,
  output logic [N_IRQ-1:0] o_pending
);

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [2:0]       id_q, id_d;
  logic [15:0]      vector_q, vector_d;
  logic             gie_q, gie_d;
  logic [N_IRQ-1:0] pending_s;
  logic [N_IRQ-1:0] cand_s;
  logic [2:0]       win_id_s;
  logic             win_valid_s;
  logic             id_mask_s;
  logic             ack_take_s;

  assign ack_take_s = i_ack && (state_q == ST_REQUEST);

  irq_pending #(.N_IRQ(N_IRQ)) u_pending (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_irq     (i_irq),
    .i_clr_en  (ack_take_s),
    .i_clr_idx (id_q),
    .o_pending (pending_s)
  );

  // Lowest enabled pending line wins; also look up the mask of the frozen id.
  always_comb begin
    cand_s      = pending_s & i_mask;
    win_valid_s = |cand_s;
    win_id_s    = 3'd0;
    id_mask_s   = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      win_id_s = cand_s[i] ? 3'(i) : win_id_s;
    end
    for (int i = 0; i < N_IRQ; i++) begin
      id_mask_s = (id_q == 3'(i)) ? i_mask[i] : id_mask_s;
    end
  end

  // Clearing the flag takes precedence over setting it.
  always_comb begin
    if (i_cli || ack_take_s) begin
      gie_d = 1'b0;
    end else if (i_sei || i_reti) begin
      gie_d = 1'b1;
    end else begin
      gie_d = gie_q;
    end
  end

  // Handshake sequencing; id and vector only change on entry to REQUEST.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    vector_d = vector_q;
    case (state_q)
      ST_IDLE: begin
        if (gie_q && win_valid_s) begin
          state_d  = ST_REQUEST;
          id_d     = win_id_s;
          vector_d = vector_addr(VECTOR_BASE, VECTOR_STRIDE, win_id_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        if (i_ack) begin
          state_d = ST_SERVICE;
        end else if (i_cli || !id_mask_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQUEST;
        end
      end
      ST_SERVICE: begin
        if (i_reti || i_sei) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d = (state_d == ST_REQUEST);
  end

  // Controller state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      id_q     <= 3'd0;
      vector_q <= VECTOR_BASE;
      gie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      id_q     <= id_d;
      vector_q <= vector_d;
      gie_q    <= gie_d;
    end
  end

  assign o_req     = req_q;
  assign o_vector  = vector_q;
  assign o_irq_id  = id_q;
  assign o_gie     = gie_q;
  assign o_pending = pending_s;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural reference model.
module tb_irq_controller;

  logic        clk;
  logic        t_rst;
  logic [3:0]  t_irq;
  logic [3:0]  t_mask;
  logic        t_sei, t_cli, t_reti, t_ack;
  logic        d_req;
  logic [15:0] d_vec;
  logic [2:0]  d_id;
  logic        d_gie;
  logic [3:0]  d_pend;

  int checks = 0;
  int errors = 0;

  irq_controller #(.N_IRQ(4), .VECTOR_BASE(16'h0002), .VECTOR_STRIDE(2)) dut (
    .i_clk     (clk),
    .i_reset   (t_rst),
    .i_irq     (t_irq),
    .i_mask    (t_mask),
    .i_sei     (t_sei),
    .i_cli     (t_cli),
    .i_reti    (t_reti),
    .i_ack     (t_ack),
    .o_req     (d_req),
    .o_vector  (d_vec),
    .o_irq_id  (d_id),
    .o_gie     (d_gie),
    .o_pending (d_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: line in request (-1 = none), in-service flag, pending bits.
  logic [3:0]  m_prev, m_pend;
  bit          m_gie, m_srv;
  int          m_line;
  int          m_id;
  logic [15:0] m_vec;

  task automatic model_step(input bit rst, input logic [3:0] irq, input logic [3:0] mask,
                            input bit sei, input bit cli, input bit reti, input bit ack);
    logic [3:0] rise, np, cand;
    bit         ng, taken;
    rise   = irq & ~m_prev;
    m_prev = irq;
    if (rst) begin
      m_pend = 4'h0; m_gie = 1'b0; m_line = -1; m_srv = 1'b0; m_id = 0; m_vec = 16'h0002;
    end else begin
      taken = ack && (m_line >= 0);
      np = m_pend;
      if (taken) np[m_line] = 1'b0;
      np = np | rise;
      ng = (cli || taken) ? 1'b0 : ((sei || reti) ? 1'b1 : m_gie);
      cand = m_pend & mask;
      if (m_line >= 0) begin
        if (ack) begin
          m_srv = 1'b1; m_line = -1;
        end else if (cli || !mask[m_line]) begin
          m_line = -1;
        end
      end else if (m_srv) begin
        if (reti || sei) m_srv = 1'b0;
      end else if (m_gie && cand != 4'h0) begin
        for (int w = 0; w < 4; w++) begin
          if (cand[w]) begin
            m_line = w; m_id = w;
            m_vec = 16'((32'h0002 + w * 2) % 65536);
            break;
          end
        end
      end
      m_pend = np;
      m_gie  = ng;
    end
  endtask

  // One clock: drive inputs away from the edge, advance model, sample after the edge.
  task automatic step(input bit rst, input logic [3:0] irq, input logic [3:0] mask,
                      input bit sei, input bit cli, input bit reti, input bit ack);
    @(negedge clk);
    t_rst = rst; t_irq = irq; t_mask = mask;
    t_sei = sei; t_cli = cli; t_reti = reti; t_ack = ack;
    @(posedge clk);
    model_step(rst, irq, mask, sei, cli, reti, ack);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input bit e_req, input logic [2:0] e_id,
                         input logic [15:0] e_vec, input bit e_gie, input logic [3:0] e_pend);
    chk({nm, ".req"},  32'(d_req),  32'(e_req));
    chk({nm, ".id"},   32'(d_id),   32'(e_id));
    chk({nm, ".vec"},  32'(d_vec),  32'(e_vec));
    chk({nm, ".gie"},  32'(d_gie),  32'(e_gie));
    chk({nm, ".pend"}, 32'(d_pend), 32'(e_pend));
  endtask

  typedef struct {
    logic [3:0]  irq;
    bit          sei, cli, reti, ack;
    bit          e_req;
    logic [2:0]  e_id;
    logic [15:0] e_vec;
    bit          e_gie;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t tbl[22];
  logic [3:0] r_irq, r_mask;

  initial begin
    t_rst = 1'b1; t_irq = 4'h0; t_mask = 4'hF;
    t_sei = 1'b0; t_cli = 1'b0; t_reti = 1'b0; t_ack = 1'b0;
    m_prev = 4'h0; m_pend = 4'h0; m_gie = 1'b0; m_srv = 1'b0; m_line = -1;
    m_id = 0; m_vec = 16'h0002;

    // basic request, priority, GIE gating (mask = 4'hF throughout)
    tbl[0]  = '{4'h0, 1, 0, 0, 0, 0, 3'd0, 16'h0002, 1, 4'h0};
    tbl[1]  = '{4'h4, 0, 0, 0, 0, 0, 3'd0, 16'h0002, 1, 4'h4};
    tbl[2]  = '{4'h4, 0, 0, 0, 0, 1, 3'd2, 16'h0006, 1, 4'h4};
    tbl[3]  = '{4'h4, 0, 0, 0, 0, 1, 3'd2, 16'h0006, 1, 4'h4};
    tbl[4]  = '{4'h4, 0, 0, 0, 1, 0, 3'd2, 16'h0006, 0, 4'h0};
    tbl[5]  = '{4'hA, 0, 0, 0, 0, 0, 3'd2, 16'h0006, 0, 4'hA};
    tbl[6]  = '{4'hA, 0, 0, 0, 0, 0, 3'd2, 16'h0006, 0, 4'hA};
    tbl[7]  = '{4'hA, 0, 0, 1, 0, 0, 3'd2, 16'h0006, 1, 4'hA};
    tbl[8]  = '{4'hA, 0, 0, 0, 0, 1, 3'd1, 16'h0004, 1, 4'hA};
    tbl[9]  = '{4'hA, 0, 0, 0, 1, 0, 3'd1, 16'h0004, 0, 4'h8};
    tbl[10] = '{4'hA, 0, 0, 1, 0, 0, 3'd1, 16'h0004, 1, 4'h8};
    tbl[11] = '{4'hA, 0, 0, 0, 0, 1, 3'd3, 16'h0008, 1, 4'h8};
    tbl[12] = '{4'hA, 0, 0, 0, 1, 0, 3'd3, 16'h0008, 0, 4'h0};
    tbl[13] = '{4'hA, 0, 0, 1, 0, 0, 3'd3, 16'h0008, 1, 4'h0};
    tbl[14] = '{4'hA, 0, 0, 0, 0, 0, 3'd3, 16'h0008, 1, 4'h0};
    tbl[15] = '{4'hA, 0, 1, 0, 0, 0, 3'd3, 16'h0008, 0, 4'h0};
    tbl[16] = '{4'hB, 0, 0, 0, 0, 0, 3'd3, 16'h0008, 0, 4'h1};
    tbl[17] = '{4'hB, 0, 0, 0, 0, 0, 3'd3, 16'h0008, 0, 4'h1};
    tbl[18] = '{4'hB, 1, 0, 0, 0, 0, 3'd3, 16'h0008, 1, 4'h1};
    tbl[19] = '{4'hB, 0, 0, 0, 0, 1, 3'd0, 16'h0002, 1, 4'h1};
    tbl[20] = '{4'hB, 0, 0, 0, 1, 0, 3'd0, 16'h0002, 0, 4'h0};
    tbl[21] = '{4'hB, 0, 0, 1, 0, 0, 3'd0, 16'h0002, 1, 4'h0};

    step(1, 4'h0, 4'hF, 0, 0, 0, 0);
    step(1, 4'h0, 4'hF, 0, 0, 0, 0);
    chk_all("reset", 0, 3'd0, 16'h0002, 0, 4'h0);

    for (int i = 0; i < 22; i++) begin
      step(0, tbl[i].irq, 4'hF, tbl[i].sei, tbl[i].cli, tbl[i].reti, tbl[i].ack);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_id, tbl[i].e_vec,
              tbl[i].e_gie, tbl[i].e_pend);
    end

    // withdraw by CLI, then re-request after SEI
    step(1, 4'h0, 4'hF, 0, 0, 0, 0);
    step(0, 4'h0, 4'hF, 1, 0, 0, 0);
    step(0, 4'h4, 4'hF, 0, 0, 0, 0);
    step(0, 4'h4, 4'hF, 0, 0, 0, 0);
    chk_all("wd_req", 1, 3'd2, 16'h0006, 1, 4'h4);
    step(0, 4'h4, 4'hF, 0, 1, 0, 0);
    chk_all("wd_cli", 0, 3'd2, 16'h0006, 0, 4'h4);
    step(0, 4'h4, 4'hF, 1, 0, 0, 0);
    step(0, 4'h4, 4'hF, 0, 0, 0, 0);
    chk_all("wd_rereq", 1, 3'd2, 16'h0006, 1, 4'h4);
    // withdraw by mask drop
    step(0, 4'h4, 4'hB, 0, 0, 0, 0);
    chk_all("wd_mask", 0, 3'd2, 16'h0006, 1, 4'h4);
    step(0, 4'h4, 4'hB, 0, 0, 0, 0);
    chk("wd_masked_idle.req", 32'(d_req), 32'd0);
    step(0, 4'h4, 4'hF, 0, 0, 0, 0);
    chk_all("wd_unmask", 1, 3'd2, 16'h0006, 1, 4'h4);
    // ack and cli together: ack taken
    step(0, 4'h4, 4'hF, 0, 1, 0, 1);
    chk_all("ack_cli", 0, 3'd2, 16'h0006, 0, 4'h0);
    step(0, 4'h4, 4'hF, 0, 0, 1, 0);
    chk("srv_exit.gie", 32'(d_gie), 32'd1);
    // collision: new edge on the acknowledged line in the ack cycle
    step(0, 4'h0, 4'hF, 0, 0, 0, 0);
    step(0, 4'h4, 4'hF, 0, 0, 0, 0);
    step(0, 4'h4, 4'hF, 0, 0, 0, 0);
    chk("coll_req.req", 32'(d_req), 32'd1);
    step(0, 4'h0, 4'hF, 0, 0, 0, 0);
    step(0, 4'h4, 4'hF, 0, 0, 0, 1);
    chk_all("coll_ack", 0, 3'd2, 16'h0006, 0, 4'h4);
    step(0, 4'h4, 4'hF, 0, 0, 1, 0);
    step(0, 4'h4, 4'hF, 0, 0, 0, 0);
    chk_all("coll_rereq", 1, 3'd2, 16'h0006, 1, 4'h4);
    // reset mid-REQUEST with line 1 held high
    step(0, 4'h6, 4'hF, 0, 0, 0, 0);
    chk_all("pre_rst", 1, 3'd2, 16'h0006, 1, 4'h6);
    step(1, 4'h6, 4'hF, 0, 0, 0, 0);
    chk_all("mid_rst", 0, 3'd0, 16'h0002, 0, 4'h0);
    step(0, 4'h6, 4'hF, 1, 0, 0, 0);
    step(0, 4'h6, 4'hF, 0, 0, 0, 0);
    step(0, 4'h6, 4'hF, 0, 0, 0, 0);
    chk_all("rst_noedge", 0, 3'd0, 16'h0002, 1, 4'h0);
    step(0, 4'h0, 4'hF, 0, 0, 0, 0);
    step(0, 4'h2, 4'hF, 0, 0, 0, 0);
    step(0, 4'h2, 4'hF, 0, 0, 0, 0);
    chk_all("rst_fresh", 1, 3'd1, 16'h0004, 1, 4'h2);

    // randomized run against the reference model
    r_irq = 4'h2; r_mask = 4'hF;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) == 0) r_irq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) r_mask = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 149) == 0), r_irq, r_mask,
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0));
      chk_all($sformatf("rnd%0d", c), (m_line >= 0), 3'(m_id), m_vec, m_gie, m_pend);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
